// File: rtl/regfile_alu_datapath.sv
// Two-stage register-file/ALU execution datapath driven by the sequencer control word.
// The EX stage reads operands (with WB->EX bypass) and computes; the WB stage writes the register file.
module regfile_alu_datapath #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              exec_en,
    input  logic              selectImm,
    input  logic [REG_AW-1:0] loadReg,
    input  logic [REG_AW-1:0] readRegA,
    input  logic [REG_AW-1:0] readRegB,
    input  logic [IMM_W-1:0]  Imm,
    input  logic [7:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [3:0]        flags,
    output logic              illegal_op,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int NREG = 1 << REG_AW;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_LSH  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;

    logic [NREG-1:0][DATA_W-1:0] rf_q, rf_d;
    logic [REG_AW-1:0]           wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]           wb_data_q, wb_data_d;
    logic                        wb_we_q, wb_we_d;
    logic [DATA_W-1:0]           result_q, result_d;
    logic                        result_valid_q, result_valid_d;
    logic [3:0]                  flags_q, flags_d;
    logic                        illegal_q, illegal_d;

    logic [DATA_W-1:0] opa, opb, alu_res;
    logic [DATA_W:0]   ext;
    logic              alu_write, alu_illegal, upd_all, upd_zn;
    logic              c_new, f_new;

    // Operand fetch: the pending WB write is newer than the register file, so it wins.
    always_comb begin
        opa = (wb_we_q && wb_dest_q == readRegA) ? wb_data_q : rf_q[readRegA];
        if (selectImm)
            opb = {{(DATA_W-IMM_W){Imm[IMM_W-1]}}, Imm};
        else
            opb = (wb_we_q && wb_dest_q == readRegB) ? wb_data_q : rf_q[readRegB];
    end

    always_comb begin
        ext         = '0;
        alu_res     = '0;
        alu_write   = 1'b1;
        alu_illegal = 1'b0;
        upd_all     = 1'b0;
        upd_zn      = 1'b0;
        c_new       = 1'b0;
        f_new       = 1'b0;
        case (op)
            OP_AND: begin alu_res = opa & opb; upd_zn = 1'b1; end
            OP_OR:  begin alu_res = opa | opb; upd_zn = 1'b1; end
            OP_XOR: begin alu_res = opa ^ opb; upd_zn = 1'b1; end
            OP_LSH: alu_res = opa << opb[3:0];
            OP_MOV: alu_res = opb;
            OP_ADD, OP_ADDC: begin
                ext     = {1'b0, opa} + {1'b0, opb}
                        + {{DATA_W{1'b0}}, (op == OP_ADDC) & flags_q[3]};
                alu_res = ext[DATA_W-1:0];
                c_new   = ext[DATA_W];
                f_new   = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
                upd_all = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // Top bit of the widened difference is the borrow (A < B unsigned).
                ext       = {1'b0, opa} - {1'b0, opb};
                alu_res   = ext[DATA_W-1:0];
                c_new     = ext[DATA_W];
                f_new     = (opa[DATA_W-1] != opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
                upd_all   = 1'b1;
                alu_write = (op == OP_SUB);
            end
            default: begin
                alu_write   = 1'b0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_we_q)
            rf_d[wb_dest_q] = wb_data_q;

        wb_dest_d      = wb_dest_q;
        wb_data_d      = wb_data_q;
        wb_we_d        = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        flags_d        = flags_q;
        illegal_d      = 1'b0;
        if (exec_en) begin
            wb_dest_d      = loadReg;
            wb_data_d      = alu_res;
            wb_we_d        = alu_write;
            result_d       = alu_res;
            result_valid_d = 1'b1;
            illegal_d      = alu_illegal;
            if (upd_all)
                flags_d = {c_new, f_new, alu_res == '0, alu_res[DATA_W-1]};
            else if (upd_zn)
                flags_d = {flags_q[3:2], alu_res == '0, alu_res[DATA_W-1]};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rf_q           <= '0;
            wb_dest_q      <= '0;
            wb_data_q      <= '0;
            wb_we_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            flags_q        <= '0;
            illegal_q      <= 1'b0;
        end else begin
            rf_q           <= rf_d;
            wb_dest_q      <= wb_dest_d;
            wb_data_q      <= wb_data_d;
            wb_we_q        <= wb_we_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            flags_q        <= flags_d;
            illegal_q      <= illegal_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign flags        = flags_q;
    assign illegal_op   = illegal_q;
    assign dbg_data     = rf_q[dbg_sel];
endmodule
